sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares the single SRAM_Controller between two memory requesters: port 0 is the instruction-side fetch path and port 1 is the data-side cache controller.
- Sits between the requesters and the SRAM_Controller, and owns the rd_en/wr_en/address/write_data side of the SRAM_Controller.
- Grants one whole transaction at a time, then holds a one-cycle release gap before the next grant.
- Arbitration is round-robin or fixed-priority, selected by parameter.

Parameters:
RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 1 always wins ties
ADDR_W, 32, request/SRAM address width
DATA_W, 32, write data width
RDATA_W, 64, read data width returned by the SRAM_Controller

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
p0_rd_en  input  1  port 0 read request (level, held until p0_ready)
p0_wr_en  input  1  port 0 write request (level, held until p0_ready)
p0_address  input  ADDR_W  port 0 address
p0_wdata  input  DATA_W  port 0 write data
p0_rdata  output  RDATA_W  port 0 read data
p0_ready  output  1  port 0 transaction complete, 1-cycle pulse
p1_rd_en, p1_wr_en, p1_address, p1_wdata, p1_rdata, p1_ready  same as port 0, for port 1
sram_rd_en  output  1  read enable to SRAM_Controller
sram_wr_en  output  1  write enable to SRAM_Controller
sram_address  output  ADDR_W  address to SRAM_Controller
sram_wdata  output  DATA_W  write data to SRAM_Controller
sram_rdata  input  RDATA_W  read data from SRAM_Controller
sram_ready  input  1  SRAM_Controller done, 1-cycle pulse
busy  output  1  high in BUSY state
owner  output  1  port currently or last granted

Behaviour:
- Reset: rst=0 at a clk edge forces state=IDLE and clears sram_rd_en, sram_wr_en, sram_address, sram_wdata, owner and last (the round-robin pointer).
  - busy=0, p0_ready=0 and p1_ready=0.
  - Reset applies mid-transaction as well; the aborted transaction never produces a ready pulse.
- States: IDLE, BUSY, RELEASE.
- Request decode per port: req = rd_en | wr_en. If rd_en and wr_en are both high, the write wins and the read is ignored.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one port requesting: grant that port.
  - Both ports requesting, RR_EN=1: grant ~last. RR_EN=0: grant port 1.
  - On grant, at the next edge: state=BUSY, owner=granted port, last=granted port.
  - Also at that edge, register sram_address and sram_wdata from the granted port, and register sram_wr_en and sram_rd_en from the decoded request type.
  - Latency: request sampled in cycle N, SRAM enables high in cycle N+1.
- BUSY:
  - sram_* outputs hold their latched values; changes on requester inputs are ignored.
  - p<owner>_ready = sram_ready (combinational). The non-owner ready stays 0.
  - p<owner>_rdata = sram_rdata at all times when owner matches. The non-owner rdata is 0.
  - On sram_ready: at the next edge, state=RELEASE and sram_rd_en=sram_wr_en=0.
- RELEASE:
  - Enables stay low for exactly one cycle, then state=IDLE. Arbitration resumes in IDLE.
  - Requesters must drop rd_en/wr_en by the cycle after their ready pulse; a request still high in IDLE is treated as a new transaction.
- Minimum back-to-back spacing: ready in cycle M, next grant decision in cycle M+2, next enables high in cycle M+3.
- sram_ready outside BUSY is ignored.
- A requester dropping its request during BUSY does not abort the transaction; ready still pulses.
- Round-robin: last updates only on grant, so a lone requester can be granted repeatedly. With both ports requesting continuously, grants strictly alternate.

Test Plan:
- Port 0 read, p0_address=0x400, no port 1 traffic; SRAM model asserts ready 4 cycles after enable with rdata=0x1122334455667788 -> sram_rd_en high one cycle after request, sram_address=0x400, p0_ready pulses once with p0_rdata=0x1122334455667788, enables low for exactly 1 cycle (RELEASE), busy=0 afterwards.
- Port 1 write, address=0x404, wdata=0xDEADBEEF -> sram_wr_en=1, sram_wdata=0xDEADBEEF, sram_rd_en=0, p1_ready pulses once, p0_ready stays 0 throughout.
- RR_EN=1, both ports request reads continuously after reset -> grant sequence 1,0,1,0 (last=0 after reset, so ~last=1 first), each grant separated by a RELEASE cycle, p0_address/p1_address presented alternately.
- RR_EN=0, both ports request 3 times -> port 1 served all 3 times before port 0; port 0 is served once port 1 drops its request.
- Reset (rst=0 for 1 cycle) issued 2 cycles into a BUSY port 0 read -> next cycle sram_rd_en=0 and busy=0; a sram_ready arriving afterwards produces no p0_ready.
- Port 0 asserts rd_en and wr_en together with wdata=0x5A5A5A5A; port 0 also changes p0_address mid-BUSY -> write performed (sram_wr_en=1, sram_rd_en=0) at the originally latched address.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM_Controller between the fetch path (port 0)
// and the data cache (port 1), one whole transaction per grant.
module sram_arbiter #(
  parameter bit RR_EN   = 1'b1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_rd_en,
  input  logic               p0_wr_en,
  input  logic [ADDR_W-1:0]  p0_address,
  input  logic [DATA_W-1:0]  p0_wdata,
  output logic [RDATA_W-1:0] p0_rdata,
  output logic               p0_ready,
  input  logic               p1_rd_en,
  input  logic               p1_wr_en,
  input  logic [ADDR_W-1:0]  p1_address,
  input  logic [DATA_W-1:0]  p1_wdata,
  output logic [RDATA_W-1:0] p1_rdata,
  output logic               p1_ready,
  output logic               sram_rd_en,
  output logic               sram_wr_en,
  output logic [ADDR_W-1:0]  sram_address,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [RDATA_W-1:0] sram_rdata,
  input  logic               sram_ready,
  output logic               busy,
  output logic               owner
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]        state;
  logic              last;
  logic              req0;
  logic              req1;
  logic              gnt;
  logic              gnt_wr;
  logic              gnt_rd;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  assign req0 = p0_rd_en | p0_wr_en;
  assign req1 = p1_rd_en | p1_wr_en;

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      req0 & req1:  gnt = RR_EN ? ~last : 1'b1;
      req1 & ~req0: gnt = 1'b1;
      default:      gnt = 1'b0;
    endcase
  end

  // write beats read when a port raises both enables
  assign gnt_wr    = gnt ? p1_wr_en : p0_wr_en;
  assign gnt_rd    = ~gnt_wr & (gnt ? p1_rd_en : p0_rd_en);
  assign gnt_addr  = gnt ? p1_address : p0_address;
  assign gnt_wdata = gnt ? p1_wdata : p0_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
      owner        <= 1'b0;
      last         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            state        <= BUSY;
            owner        <= gnt;
            last         <= gnt;
            sram_address <= gnt_addr;
            sram_wdata   <= gnt_wdata;
            sram_wr_en   <= gnt_wr;
            sram_rd_en   <= gnt_rd;
          end
        end
        BUSY: begin
          if (sram_ready) begin
            state      <= RELEASE;
            sram_rd_en <= 1'b0;
            sram_wr_en <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == BUSY);
  assign p0_ready = busy & ~owner & sram_ready;
  assign p1_ready = busy & owner & sram_ready;
  assign p0_rdata = owner ? '0 : sram_rdata;
  assign p1_rdata = owner ? sram_rdata : '0;

endmodule
